pulse_frame_tx: RTL and testbench

Transmit-side serializer for the pulse propagation time meter. It accepts a parallel word over a valid/ready handshake and sends it as a framed serial pulse train: a start pulse, the data bits in the selected order, then a low guard interval. It feeds the wireless transmitter front end and pairs with the receiver's serial-in shift register. A one-cycle timestamp mark on the start pulse provides the propagation-time reference.

---
 rtl/pulse_tx_pkg.sv | 14 +
 rtl/bit_timer.sv | 32 +++
 rtl/pulse_frame_tx.sv | 125 ++++++++++++
 tb/tb_pulse_frame_tx.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pulse_tx_pkg.sv
// Shared framing definitions for the pulse transmitter and the receiver-side framing logic.
package pulse_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        GUARD = 2'd3
    } tx_state_t;

    localparam logic IDLE_LEVEL  = 1'b0;
    localparam logic START_LEVEL = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 and ticks in the last cycle of each period.
module bit_timer #(
    parameter int BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign tick = en && !clear && (cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (en) begin
            if (clear || cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pulse_frame_tx.sv
// Framed serial pulse transmitter: start pulse, MSB data bits in the chosen order, then a low guard.
module pulse_frame_tx
    import pulse_tx_pkg::*;
#(
    parameter int MSB        = 12,
    parameter int BIT_CYCLES = 4,
    parameter int GUARD      = 2
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           en,
    input  logic           dir,
    input  logic           load_valid,
    output logic           load_ready,
    input  logic [MSB-1:0] din,
    output logic           q,
    output logic           tx_mark,
    output logic           busy,
    output logic           done
);

    localparam int BW_DATA  = $clog2(MSB + 1);
    localparam int BW_GUARD = (GUARD > 1) ? $clog2(GUARD) : 1;
    localparam int BW       = (BW_DATA > BW_GUARD) ? BW_DATA : BW_GUARD;
    localparam logic [BW-1:0] DATA_LAST  = BW'(MSB);
    localparam logic [BW-1:0] GUARD_LAST = BW'(GUARD - 1);

    tx_state_t      state;
    logic [MSB-1:0] sreg;
    logic           order;
    logic [BW-1:0]  bitcnt;
    logic           q_r;
    logic           mark_r;
    logic           done_r;
    logic           busy_r;
    logic           tick;
    logic           accept;
    logic           next_bit;
    logic [MSB-1:0] next_sreg;

    assign load_ready = rstn && en && (state == IDLE);
    assign accept     = load_valid && load_ready;

    assign next_bit  = order ? sreg[0] : sreg[MSB-1];
    assign next_sreg = order ? {1'b0, sreg[MSB-1:1]} : {sreg[MSB-2:0], 1'b0};

    // Holding the timer clear while idle puts every frame's START on counter phase 0.
    bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
        .clk   (clk),
        .rstn  (rstn),
        .en    (en),
        .clear (state == IDLE),
        .tick  (tick)
    );

    // The enum literal GUARD is shadowed by the parameter of the same name, hence the package scope.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            sreg   <= '0;
            order  <= 1'b0;
            bitcnt <= '0;
            q_r    <= IDLE_LEVEL;
            mark_r <= 1'b0;
            done_r <= 1'b0;
            busy_r <= 1'b0;
        end else if (en) begin
            mark_r <= 1'b0;
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        sreg   <= din;
                        order  <= dir;
                        bitcnt <= '0;
                        q_r    <= START_LEVEL;
                        mark_r <= 1'b1;
                        busy_r <= 1'b1;
                        state  <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        q_r    <= next_bit;
                        sreg   <= next_sreg;
                        bitcnt <= BW'(1);
                        state  <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bitcnt == DATA_LAST) begin
                            q_r    <= IDLE_LEVEL;
                            bitcnt <= '0;
                            state  <= pulse_tx_pkg::GUARD;
                        end else begin
                            q_r    <= next_bit;
                            sreg   <= next_sreg;
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end
                end
                pulse_tx_pkg::GUARD: begin
                    if (tick) begin
                        if (bitcnt == GUARD_LAST) begin
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pulse flags hold while en is low, so gating them here defers rather than drops them.
    assign q       = q_r;
    assign busy    = busy_r;
    assign tx_mark = mark_r && en;
    assign done    = done_r && en;

endmodule

// File: tb/tb_pulse_frame_tx.sv
// Directed bench for pulse_frame_tx: default-size instance plus a minimal 2-bit, 1-cycle instance.
module tb_pulse_frame_tx;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic        dir;
    logic        load_valid;
    logic        load_ready;
    logic [11:0] din;
    logic        q;
    logic        tx_mark;
    logic        busy;
    logic        done;

    logic        s_dir;
    logic        s_valid;
    logic        s_ready;
    logic [1:0]  s_din;
    logic        s_q;
    logic        s_mark;
    logic        s_busy;
    logic        s_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pulse_frame_tx dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .dir        (dir),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .din        (din),
        .q          (q),
        .tx_mark    (tx_mark),
        .busy       (busy),
        .done       (done)
    );

    pulse_frame_tx #(.MSB(2), .BIT_CYCLES(1), .GUARD(1)) dut_s (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .dir        (s_dir),
        .load_valid (s_valid),
        .load_ready (s_ready),
        .din        (s_din),
        .q          (s_q),
        .tx_mark    (s_mark),
        .busy       (s_busy),
        .done       (s_done)
    );

    task automatic check(input string tag, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Called at the falling edge of the first START cycle; walks the 60-cycle frame and
    // finishes at the falling edge of the done cycle. bits lists data bits in send order.
    task automatic watch_frame(input string tag, input logic [11:0] bits,
                               input int chg_k, input logic [11:0] chg_din, input logic chg_dir,
                               input int drop_k, input int stop_k);
        logic exp_q;
        for (int k = 0; k < 60; k++) begin
            if (k < 4)       exp_q = 1'b1;
            else if (k < 52) exp_q = bits[11 - (k - 4) / 4];
            else             exp_q = 1'b0;
            check($sformatf("%s_q@%0d", tag, k), q, exp_q);
            check($sformatf("%s_busy@%0d", tag, k), busy, 1'b1);
            check($sformatf("%s_mark@%0d", tag, k), tx_mark, k == 0);
            check($sformatf("%s_done@%0d", tag, k), done, 1'b0);
            check($sformatf("%s_ready@%0d", tag, k), load_ready, 1'b0);
            if (k == stop_k) return;
            if (k == chg_k) begin
                din = chg_din;
                dir = chg_dir;
            end
            if (k == drop_k) begin
                en = 1'b0;
                repeat (7) begin
                    @(negedge clk);
                    check($sformatf("%s_hold_q@%0d", tag, k), q, exp_q);
                    check($sformatf("%s_hold_busy@%0d", tag, k), busy, 1'b1);
                    check($sformatf("%s_hold_ready@%0d", tag, k), load_ready, 1'b0);
                end
                en = 1'b1;
            end
            @(negedge clk);
        end
        check({tag, "_end_done"}, done, 1'b1);
        check({tag, "_end_busy"}, busy, 1'b0);
        check({tag, "_end_q"}, q, 1'b0);
        check({tag, "_end_ready"}, load_ready, 1'b1);
        check({tag, "_end_mark"}, tx_mark, 1'b0);
    endtask

    initial begin
        rstn       = 1'b0;
        en         = 1'b1;
        dir        = 1'b0;
        load_valid = 1'b0;
        din        = '0;
        s_dir      = 1'b0;
        s_valid    = 1'b0;
        s_din      = '0;

        repeat (2) @(negedge clk);
        check("rst_q", q, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", load_ready, 1'b0);
        check("rst_mark", tx_mark, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_s_ready", s_ready, 1'b0);
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_ready", load_ready, 1'b1);
        check("post_rst_s_ready", s_ready, 1'b1);

        // MSB first
        din = 12'hA5C; dir = 1'b0; load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        watch_frame("msb", 12'b1010_0101_1100, -1, 12'h000, 1'b0, -1, -1);
        @(negedge clk);
        check("msb_done_once", done, 1'b0);

        // LSB first, inputs disturbed mid-frame
        din = 12'hA5C; dir = 1'b1; load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        watch_frame("lsb", 12'b0011_1010_0101, 20, 12'hFFF, 1'b0, -1, -1);
        @(negedge clk);

        // en dropped for 7 cycles mid-DATA
        din = 12'hA5C; dir = 1'b0; load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        watch_frame("en", 12'b1010_0101_1100, -1, 12'h000, 1'b0, 26, -1);
        @(negedge clk);

        // asynchronous reset mid-DATA
        din = 12'hA5C; dir = 1'b0; load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        watch_frame("rst", 12'b1010_0101_1100, -1, 12'h000, 1'b0, -1, 34);
        #2 rstn = 1'b0;
        #1;
        check("arst_q", q, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_ready", load_ready, 1'b0);
        check("arst_done", done, 1'b0);
        @(negedge clk);
        check("arst_hold_q", q, 1'b0);
        #2 rstn = 1'b1;
        @(negedge clk);
        check("arst_rel_ready", load_ready, 1'b1);
        check("arst_rel_busy", busy, 1'b0);
        check("arst_rel_done", done, 1'b0);
        check("arst_rel_q", q, 1'b0);
        @(negedge clk);
        check("arst_rel_done2", done, 1'b0);

        // back-to-back with load_valid held high
        din = 12'hA5C; dir = 1'b0; load_valid = 1'b1;
        @(negedge clk);
        watch_frame("b2b_a", 12'b1010_0101_1100, 10, 12'h3C3, 1'b0, -1, -1);
        @(negedge clk);
        watch_frame("b2b_b", 12'b0011_1100_0011, -1, 12'h000, 1'b0, -1, -1);
        load_valid = 1'b0;
        @(negedge clk);
        check("b2b_idle_busy", busy, 1'b0);
        check("b2b_idle_ready", load_ready, 1'b1);
        check("b2b_idle_q", q, 1'b0);

        // minimal configuration
        s_din = 2'b10; s_dir = 1'b0; s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        check("s_q0", s_q, 1'b1);
        check("s_mark0", s_mark, 1'b1);
        check("s_busy0", s_busy, 1'b1);
        @(negedge clk);
        check("s_q1", s_q, 1'b1);
        check("s_mark1", s_mark, 1'b0);
        @(negedge clk);
        check("s_q2", s_q, 1'b0);
        check("s_busy2", s_busy, 1'b1);
        @(negedge clk);
        check("s_q3", s_q, 1'b0);
        check("s_done3", s_done, 1'b0);
        check("s_busy3", s_busy, 1'b1);
        @(negedge clk);
        check("s_done4", s_done, 1'b1);
        check("s_busy4", s_busy, 1'b0);
        check("s_ready4", s_ready, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
